mem_stage: RTL

Pipeline memory stage sitting directly downstream of the ALU/execute stage and upstream of writeback. Each cycle it accepts one executed instruction (opcode, ALU result, effective address, store data, destination register) and either passes the ALU result to writeback or performs a word load/store against a data memory port with a request/grant/read-valid handshake. While a memory access is outstanding it stalls the execute stage.

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: ALU pass-through, word load/store with req/gnt/rvalid handshake
//
// Optional feature macro: MEM_STAGE_ALIGN_CHK_EN (misaligned LDW/STW are trapped instead of issued).
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   ex_valid_i .. ex_dest_i  executed instruction from the execute stage
//   mem_stall_o              execute stage must hold while an access is outstanding
//   dmem_req_o .. dmem_wdata_o  data-memory request (registered)
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i  data-memory responses
//   wb_valid_o .. wb_data_o  registered writeback to the register file
//   mem_misalign_o           one-cycle misaligned-access pulse
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ex_valid_i,
    input  logic [5:0]        ex_op_i,
    input  logic [DATA_W-1:0] ex_rd_i,
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic [4:0]        ex_dest_i,
    output logic              mem_stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_dest_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              mem_misalign_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD} state_e;

    localparam logic [5:0] OP_ALU_MAX = 6'b001011;
    localparam logic [5:0] OP_LDW     = 6'b001100;
    localparam logic [5:0] OP_STW     = 6'b001101;

    state_e            state_q, state_d;
    logic              dmem_req_q, dmem_req_d;
    logic              dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0] dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0] dmem_wdata_q, dmem_wdata_d;
    logic [4:0]        dest_q, dest_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_dest_q, wb_dest_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              misalign_q, misalign_d;

    logic accept;
    logic is_mem;
    logic misalign_req;

    assign accept = ex_valid_i && (state_q == S_IDLE);
    assign is_mem = (ex_op_i == OP_LDW) || (ex_op_i == OP_STW);

`ifdef MEM_STAGE_ALIGN_CHK_EN
    assign misalign_req = |ex_addr_i[1:0];
`else
    // Low address bits are simply dropped when alignment checking is off.
    logic unused_addr_lo;
    assign unused_addr_lo = ^ex_addr_i[1:0];
    assign misalign_req   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept && is_mem && !misalign_req) state_d = S_REQ;
            S_REQ:     if (dmem_gnt_i) state_d = dmem_we_q ? S_IDLE : S_WAIT_RD;
            S_WAIT_RD: if (dmem_rvalid_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered dmem_* / wb_* outputs
    always_comb begin
        dmem_req_d   = (state_d == S_REQ);
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        dest_d       = dest_q;
        wb_valid_d   = 1'b0;
        wb_we_d      = 1'b0;
        wb_dest_d    = wb_dest_q;
        wb_data_d    = wb_data_q;
        misalign_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mem && !misalign_req) begin
                        dmem_we_d    = (ex_op_i == OP_STW);
                        dmem_addr_d  = {ex_addr_i[ADDR_W-1:2], 2'b00};
                        dmem_wdata_d = ex_wdata_i;
                        dest_d       = ex_dest_i;
                    end else begin
                        // ALU ops, non-writeback ops and trapped misaligned accesses retire here.
                        wb_valid_d = 1'b1;
                        wb_dest_d  = ex_dest_i;
                        misalign_d = is_mem;
                        if (ex_op_i <= OP_ALU_MAX) begin
                            wb_we_d   = 1'b1;
                            wb_data_d = ex_rd_i;
                        end else begin
                            wb_data_d = '0;
                        end
                    end
                end
            end
            S_REQ: begin
                if (dmem_gnt_i && dmem_we_q) begin
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q;
                    wb_data_d  = '0;
                end
            end
            S_WAIT_RD: begin
                if (dmem_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = 1'b1;
                    wb_dest_d  = dest_q;
                    wb_data_d  = dmem_rdata_i;
                end
            end
            default: ;
        endcase
    end

    // Datapath / output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dest_q       <= '0;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_dest_q    <= '0;
            wb_data_q    <= '0;
            misalign_q   <= 1'b0;
        end else begin
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            dest_q       <= dest_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_dest_q    <= wb_dest_d;
            wb_data_q    <= wb_data_d;
            misalign_q   <= misalign_d;
        end
    end

    assign mem_stall_o    = (state_q != S_IDLE);
    assign dmem_req_o     = dmem_req_q;
    assign dmem_we_o      = dmem_we_q;
    assign dmem_addr_o    = dmem_addr_q;
    assign dmem_wdata_o   = dmem_wdata_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_we_o        = wb_we_q;
    assign wb_dest_o      = wb_dest_q;
    assign wb_data_o      = wb_data_q;
    assign mem_misalign_o = misalign_q;

endmodule
